// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, FSM state
// encodings and the default reset PC.
package fetch_stage_pkg;

  localparam logic [31:0] NOP          = 32'b0;
  localparam logic [31:0] RESET_PC_DEF = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_cla32.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups
// chained through a group-level carry.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, group carries, then per-bit carries and sum
  always_comb begin
    logic [7:0]  gg;
    logic [7:0]  pg;
    logic [8:0]  gc;
    logic [31:0] c;
    gg    = '0;
    pg    = '0;
    gc    = '0;
    c     = '0;
    sum   = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (pg[k] & gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum = p ^ c;
  end

endmodule

// File: rtl/fetch_stage_hold_buffer.sv
// One-entry skid register that captures a fetched instruction while the
// decode side is stalled, so no returned word is ever lost to a stall.
module fetch_hold_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_in,
  output logic [31:0] hold_ir,
  output logic [31:0] hold_pc
);

  // Capture on load; a flush (clear) discards the held entry
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      hold_ir <= '0;
      hold_pc <= '0;
    end else if (load) begin
      hold_ir <= ir_in;
      hold_pc <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues word-addressed instruction memory
// requests over req/ack, fills the F/D latch and honours execute-stage
// redirects by flushing F/D and dropping any outstanding fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc_next_def,
  output logic [31:0]       fd_pc_out,
  output logic [31:0]       fd_ir_out,
  output logic              fd_valid
);

  fetch_state_e      state_p0;
  logic [31:0]       pc_p0;
  logic [31:0]       pc_inc;
  logic              req_p0;
  logic [ADDR_W-1:0] drop_addr_p0;
  logic [31:0]       fd_ir_p1;
  logic [31:0]       fd_pc_p1;
  logic              vld_p1;
  logic [31:0]       hold_ir;
  logic [31:0]       hold_pc;
  logic              hold_load;
  logic              hold_clear;

  // Single shared incrementer: pc + 1 feeds both pc_next_def and F/D pc
  cla32 u_pc_inc (
    .a   (pc_p0),
    .b   (32'd0),
    .cin (1'b1),
    .sum (pc_inc)
  );

  // Word returned while decode is stalled goes to the skid entry
  assign hold_load  = (state_p0 == ST_FETCH) && imem_ack && stall && !redirect;
  assign hold_clear = redirect && (state_p0 != ST_IDLE);

  fetch_hold_buffer u_hold (
    .clock   (clock),
    .reset   (reset),
    .load    (hold_load),
    .clear   (hold_clear),
    .ir_in   (imem_rdata),
    .pc_in   (pc_inc),
    .hold_ir (hold_ir),
    .hold_pc (hold_pc)
  );

  assign pc_next_def = pc_inc;
  assign imem_req    = req_p0;
  // While dropping, keep presenting the abandoned address until memory acks it
  assign imem_addr   = (state_p0 == ST_DROP) ? drop_addr_p0 : pc_p0[ADDR_W-1:0];
  assign fd_ir_out   = fd_ir_p1;
  assign fd_pc_out   = fd_pc_p1;
  assign fd_valid    = vld_p1;

  // Fetch FSM with PC, F/D latch and registered request
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_p0     <= ST_IDLE;
      req_p0       <= 1'b0;
      pc_p0        <= RESET_PC;
      drop_addr_p0 <= '0;
      fd_ir_p1     <= NOP;
      fd_pc_p1     <= '0;
      vld_p1       <= 1'b0;
    end else if (state_p0 == ST_IDLE) begin
      state_p0 <= ST_FETCH;
      req_p0   <= 1'b1;
      if (redirect) pc_p0 <= redirect_pc;
    end else if (redirect) begin
      // Flush wins over stall and ack; fd_pc is left as it was
      fd_ir_p1 <= NOP;
      vld_p1   <= 1'b0;
      pc_p0    <= redirect_pc;
      req_p0   <= 1'b1;
      if (state_p0 == ST_FETCH && !imem_ack) begin
        state_p0     <= ST_DROP;
        drop_addr_p0 <= pc_p0[ADDR_W-1:0];
      end else if (state_p0 == ST_DROP) begin
        state_p0 <= ST_DROP;
      end else begin
        state_p0 <= ST_FETCH;
      end
    end else if (state_p0 == ST_FETCH) begin
      if (imem_ack) begin
        pc_p0 <= pc_inc;
        if (stall) begin
          state_p0 <= ST_HOLD;
          req_p0   <= 1'b0;
        end else begin
          fd_ir_p1 <= imem_rdata;
          fd_pc_p1 <= pc_inc;
          vld_p1   <= 1'b1;
        end
      end
    end else if (state_p0 == ST_HOLD) begin
      if (!stall) begin
        fd_ir_p1 <= hold_ir;
        fd_pc_p1 <= hold_pc;
        vld_p1   <= 1'b1;
        state_p0 <= ST_FETCH;
        req_p0   <= 1'b1;
      end
    end else begin
      // Dropping: the stale word is discarded, then fetch resumes at pc
      if (imem_ack) state_p0 <= ST_FETCH;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a behavioural model.
module tb_fetch_stage;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          stall = 1'b0;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   pc_next_def;
  logic [31:0]   fd_pc_out;
  logic [31:0]   fd_ir_out;
  logic          fd_valid;

  always #5 clock = ~clock;

  fetch_stage #(.ADDR_W(AW), .RESET_PC(32'd0)) dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_next_def (pc_next_def),
    .fd_pc_out   (fd_pc_out),
    .fd_ir_out   (fd_ir_out),
    .fd_valid    (fd_valid)
  );

  int total = 0;
  int bad   = 0;

  // stimulus controls
  bit          rst_d = 1'b0;
  bit          red_d = 1'b0;
  bit [31:0]   rpc_d = '0;
  bit          stl_d = 1'b0;
  bit          want_ack = 1'b0;
  bit          lat_mode = 1'b0;
  int          lat = 0;
  int          waitc = 0;
  bit          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  // behavioural model: what the fetch unit is doing, not how
  bit [31:0] m_pc;
  bit        m_idle = 1'b1;
  bit        m_holding = 1'b0;
  bit [31:0] m_hold_ir, m_hold_pc;
  bit        m_dropping = 1'b0;
  bit [AW-1:0] m_drop_addr;
  bit [31:0] m_fd_ir, m_fd_pc;
  bit        m_fd_v;

  function automatic logic [31:0] data_for(input logic [AW-1:0] a);
    return {20'd0, a} + 32'd100;
  endfunction

  function automatic bit m_req();
    return !m_idle && !m_holding;
  endfunction

  function automatic bit [AW-1:0] m_addr();
    return m_dropping ? m_drop_addr : m_pc[AW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_step(input bit rst_n, input bit red, input bit [31:0] rpc,
                        input bit stl, input bit ack);
    if (!rst_n) begin
      m_pc = 32'd0; m_idle = 1; m_holding = 0; m_dropping = 0;
      m_fd_ir = 0; m_fd_pc = 0; m_fd_v = 0; m_hold_ir = 0; m_hold_pc = 0;
    end else if (m_idle) begin
      m_idle = 0;
      if (red) m_pc = rpc;
    end else if (red) begin
      m_fd_ir = 0; m_fd_v = 0;
      if (m_holding) m_holding = 0;
      else if (!m_dropping && !ack) begin
        m_dropping = 1; m_drop_addr = m_pc[AW-1:0];
      end
      m_pc = rpc;
    end else if (m_dropping) begin
      if (ack) m_dropping = 0;
    end else if (m_holding) begin
      if (!stl) begin
        m_fd_ir = m_hold_ir; m_fd_pc = m_hold_pc; m_fd_v = 1; m_holding = 0;
      end
    end else if (ack) begin
      if (stl) begin
        m_hold_ir = data_for(m_pc[AW-1:0]); m_hold_pc = m_pc + 1; m_holding = 1;
      end else begin
        m_fd_ir = data_for(m_pc[AW-1:0]); m_fd_pc = m_pc + 1; m_fd_v = 1;
      end
      m_pc = m_pc + 1;
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
    chk("imem_addr", {20'd0, imem_addr}, {20'd0, m_addr()});
    chk("pc_next_def", pc_next_def, m_pc + 32'd1);
    chk("fd_ir_out", fd_ir_out, m_fd_ir);
    chk("fd_pc_out", fd_pc_out, m_fd_pc);
    chk("fd_valid", {31'd0, fd_valid}, {31'd0, m_fd_v});
  endtask

  // one clock: drive at negedge (memory reacts to current request), check after posedge
  task automatic tick();
    @(negedge clock);
    if (prev_wait && imem_req)
      chk("addr_stable", {20'd0, imem_addr}, {20'd0, prev_addr});
    if (lat_mode) imem_ack = imem_req && (waitc >= lat);
    else          imem_ack = imem_req && want_ack;
    imem_rdata  = data_for(imem_addr);
    reset       = rst_d;
    redirect    = red_d;
    redirect_pc = rpc_d;
    stall       = stl_d;
    prev_wait   = rst_d && imem_req && !imem_ack;
    prev_addr   = imem_addr;
    waitc       = prev_wait ? waitc + 1 : 0;
    m_step(rst_d, red_d, rpc_d, stl_d, imem_ack);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    // reset, then streaming with zero-latency memory
    rst_d = 0; want_ack = 1;
    tick(); tick();
    chk("lit_rst_req", {31'd0, imem_req}, 32'd0);
    chk("lit_rst_vld", {31'd0, fd_valid}, 32'd0);
    chk("lit_rst_ir", fd_ir_out, 32'd0);
    rst_d = 1;
    tick();
    chk("lit_first_req", {31'd0, imem_req}, 32'd1);
    chk("lit_first_addr", {20'd0, imem_addr}, 32'd0);
    chk("lit_first_pcn", pc_next_def, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_stream_ir", fd_ir_out, 32'd100 + i);
      chk("lit_stream_pc", fd_pc_out, 32'd1 + i);
      chk("lit_stream_vld", {31'd0, fd_valid}, 32'd1);
    end

    // stall for 3 cycles with ack high
    stl_d = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_stall_ir", fd_ir_out, 32'd102);
      chk("lit_stall_req", {31'd0, imem_req}, 32'd0);
    end
    stl_d = 0;
    tick();
    chk("lit_release_ir", fd_ir_out, 32'd103);
    chk("lit_release_pc", fd_pc_out, 32'd4);
    tick();
    chk("lit_resume_ir", fd_ir_out, 32'd104);

    // redirect while a fetch is outstanding
    want_ack = 0; red_d = 1; rpc_d = 32'h40;
    tick();
    red_d = 0;
    chk("lit_flush_ir", fd_ir_out, 32'd0);
    chk("lit_flush_vld", {31'd0, fd_valid}, 32'd0);
    chk("lit_flush_pc", fd_pc_out, 32'd5);
    chk("lit_drop_addr", {20'd0, imem_addr}, 32'd5);
    tick(); tick();
    chk("lit_drop_addr2", {20'd0, imem_addr}, 32'd5);
    want_ack = 1;
    tick();
    chk("lit_after_drop_addr", {20'd0, imem_addr}, 32'h40);
    chk("lit_after_drop_vld", {31'd0, fd_valid}, 32'd0);
    tick();
    chk("lit_target_ir", fd_ir_out, 32'h40 + 32'd100);
    chk("lit_target_pc", fd_pc_out, 32'h41);

    // redirect and stall together while holding
    stl_d = 1;
    tick();
    red_d = 1; rpc_d = 32'h80;
    tick();
    red_d = 0; stl_d = 0;
    chk("lit_hold_flush_ir", fd_ir_out, 32'd0);
    chk("lit_hold_flush_req", {31'd0, imem_req}, 32'd1);
    chk("lit_hold_flush_addr", {20'd0, imem_addr}, 32'h80);
    tick();
    chk("lit_post_hold_ir", fd_ir_out, 32'h80 + 32'd100);
    chk("lit_post_hold_pc", fd_pc_out, 32'h81);

    // PC wrap, then reset in the middle of a drop
    red_d = 1; rpc_d = 32'hFFFF_FFFF;
    tick();
    red_d = 0;
    chk("lit_wrap_pcn", pc_next_def, 32'd0);
    chk("lit_wrap_addr", {20'd0, imem_addr}, 32'hFFF);
    tick();
    chk("lit_wrap_fdpc", fd_pc_out, 32'd0);
    chk("lit_wrap_ir", fd_ir_out, 32'hFFF + 32'd100);
    chk("lit_wrap_next", {20'd0, imem_addr}, 32'd0);
    want_ack = 0; red_d = 1; rpc_d = 32'h10;
    tick();
    red_d = 0;
    chk("lit_drop_req", {31'd0, imem_req}, 32'd1);
    rst_d = 0;
    tick();
    chk("lit_midrop_req", {31'd0, imem_req}, 32'd0);
    chk("lit_midrop_pcn", pc_next_def, 32'd1);
    rst_d = 1;
    tick();
    chk("lit_restart_addr", {20'd0, imem_addr}, 32'd0);

    // ack delayed by 2 cycles per fetch
    lat_mode = 1; lat = 2;
    for (int i = 0; i < 15; i++) tick();
    lat_mode = 0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_d    = ($urandom_range(0, 199) != 0);
      want_ack = ($urandom_range(0, 9) < 6);
      stl_d    = ($urandom_range(0, 9) < 3);
      red_d    = ($urandom_range(0, 9) == 0);
      rpc_d    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
